uart_rx_fifo_writer: RTL and testbench

Receive-side counterpart of the UART transmit FSM: accepts byte strobes from the UART receiver and writes them into the receive FIFO that feeds the DDR3 write path. It absorbs short FIFO-full stalls in a 2-entry holding buffer, reports overruns, and pulses a packet-complete flag every `PKT_BYTES` bytes committed to the FIFO. It sits between the UART receiver and the RX FIFO.

---
 rtl/uart_rx_fifo_writer.sv | 120 ++++++++++++
 tb/tb_uart_rx_fifo_writer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_writer.sv
// Moves UART receive bytes into the RX FIFO through a 2-entry holding buffer.
// Write latency is 2 cycles, writes are spaced at least 2 cycles apart; bytes that arrive while the buffer is full are dropped and counted.
module uart_rx_fifo_writer #(
  parameter int PKT_BYTES = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             fifo_full,
  output logic             o_wren_fifo,
  output logic [7:0]       o_fifo_data,
  output logic             o_pkt_done,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_drop_count,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [15:0] PKT_LAST = 16'(PKT_BYTES - 1);

  state_t      state;
  logic [7:0]  hold0;
  logic [7:0]  hold1;
  logic [1:0]  occ;
  logic [15:0] pkt_cnt;

  logic        pop;
  logic        push;
  logic        drop;
  logic [1:0]  occ_next;
  logic [1:0]  wr_idx;

  // The head leaves the buffer at the end of the write cycle, so a byte
  // arriving then can still take the freed slot.
  always_comb begin
    pop      = (state == WRITE);
    push     = rx_valid && ((occ != 2'd2) || pop);
    drop     = rx_valid && (occ == 2'd2) && !pop;
    occ_next = occ + 2'(push) - 2'(pop);
    wr_idx   = occ - 2'(pop);
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      hold0        <= 8'd0;
      hold1        <= 8'd0;
      occ          <= 2'd0;
      pkt_cnt      <= 16'd0;
      o_wren_fifo  <= 1'b0;
      o_fifo_data  <= 8'd0;
      o_pkt_done   <= 1'b0;
      o_overrun    <= 1'b0;
      o_drop_count <= '0;
    end else begin
      if (pop) begin
        hold0 <= hold1;
      end
      if (push) begin
        if (wr_idx == 2'd0) begin
          hold0 <= rx_data;
        end else begin
          hold1 <= rx_data;
        end
      end
      occ <= occ_next;

      if (drop) begin
        o_overrun <= 1'b1;
        if (o_drop_count != '1) begin
          o_drop_count <= o_drop_count + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (push) begin
            state <= CHECK;
          end
        end
        // fifo_full here already reflects any previous write, since a
        // write is always followed by at least one CHECK cycle.
        CHECK: begin
          if (!fifo_full) begin
            state       <= WRITE;
            o_wren_fifo <= 1'b1;
            o_fifo_data <= hold0;
            if (pkt_cnt == PKT_LAST) begin
              pkt_cnt    <= 16'd0;
              o_pkt_done <= 1'b1;
            end else begin
              pkt_cnt    <= pkt_cnt + 16'd1;
              o_pkt_done <= 1'b0;
            end
          end
        end
        WRITE: begin
          o_wren_fifo <= 1'b0;
          o_pkt_done  <= 1'b0;
          state       <= (occ_next != 2'd0) ? CHECK : IDLE;
        end
        default: begin
          state       <= IDLE;
          o_wren_fifo <= 1'b0;
          o_pkt_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Bench for uart_rx_fifo_writer: directed scenarios then random traffic,
// every cycle compared against a queue-based model of the holding buffer.
module tb_uart_rx_fifo_writer;

  localparam int PKT = 4;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          fifo_full;
  logic          o_wren_fifo;
  logic [7:0]    o_fifo_data;
  logic          o_pkt_done;
  logic          o_overrun;
  logic [CW-1:0] o_drop_count;
  logic          o_busy;

  always #5 clk = ~clk;

  uart_rx_fifo_writer #(.PKT_BYTES(PKT), .CNT_W(CW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .fifo_full    (fifo_full),
    .o_wren_fifo  (o_wren_fifo),
    .o_fifo_data  (o_fifo_data),
    .o_pkt_done   (o_pkt_done),
    .o_overrun    (o_overrun),
    .o_drop_count (o_drop_count),
    .o_busy       (o_busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: bytes waiting to be written, plus what the outputs should show.
  logic [7:0]    mq[$];
  bit            exp_wr;
  bit            exp_pd;
  bit            ovr;
  logic [7:0]    last_data;
  logic [CW-1:0] drops;
  int            wcount;
  bit            chk_en = 1'b0;
  int            pd_seen;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int old_size;
    bit wr_now;
    if (!rstn) begin
      mq.delete();
      exp_wr    = 1'b0;
      exp_pd    = 1'b0;
      ovr       = 1'b0;
      drops     = '0;
      last_data = 8'd0;
      wcount    = 0;
      chk_en    = 1'b1;
    end else begin
      old_size = mq.size();
      wr_now   = exp_wr;
      if (wr_now) void'(mq.pop_front());
      if (rx_valid) begin
        if (mq.size() < 2) mq.push_back(rx_data);
        else begin
          ovr = 1'b1;
          if (drops != '1) drops = drops + 1'b1;
        end
      end
      // A non-empty buffer that is not being written waits for a clear FIFO.
      exp_wr = (old_size > 0) && !wr_now && !fifo_full;
      exp_pd = 1'b0;
      if (exp_wr) begin
        last_data = mq[0];
        wcount++;
        exp_pd = ((wcount % PKT) == 0);
      end
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic f);
    @(negedge clk);
    if (chk_en) begin
      check("wren",  16'(o_wren_fifo),  16'(exp_wr));
      check("data",  16'(o_fifo_data),  16'(last_data));
      check("pkt",   16'(o_pkt_done),   16'(exp_pd));
      check("ovr",   16'(o_overrun),    16'(ovr));
      check("drops", 16'(o_drop_count), 16'(drops));
      check("busy",  16'(o_busy),       16'(mq.size() > 0));
      if (o_pkt_done === 1'b1) pd_seen++;
    end
    rstn      = r;
    rx_valid  = v;
    rx_data   = d;
    fifo_full = f;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n, input logic f);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, f);
  endtask

  logic r_r, r_v, r_f;
  logic [7:0] r_d;

  initial begin
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; fifo_full = 1'b0;

    // Reset
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hEE, 1'b0);
    #1;
    check("rst_wren", 16'(o_wren_fifo), 16'd0);
    check("rst_busy", 16'(o_busy), 16'd0);
    check("rst_drop", 16'(o_drop_count), 16'd0);
    check("rst_ovr",  16'(o_overrun), 16'd0);

    // Basic write: strobe in T, write in T+2
    cyc(1'b1, 1'b1, 8'hA5, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    check("lat_wren", 16'(o_wren_fifo), 16'd1);
    check("lat_data", 16'(o_fifo_data), 16'hA5);
    idle(3, 1'b0);
    #1;
    check("basic_idle", 16'(o_busy), 16'd0);

    // Packet flag over 8 spaced bytes; 0xA5 was write 1, so reset the count first
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    pd_seen = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b1, 8'(i), 1'b0);
      idle(9, 1'b0);
    end
    check("pkt_pulses", 16'(pd_seen), 16'd2);

    // Stall and drop
    cyc(1'b1, 1'b1, 8'h11, 1'b1);
    cyc(1'b1, 1'b1, 8'h22, 1'b1);
    cyc(1'b1, 1'b1, 8'h33, 1'b1);
    idle(3, 1'b1);
    #1;
    check("stall_ovr",  16'(o_overrun), 16'd1);
    check("stall_drop", 16'(o_drop_count), 16'd1);
    check("stall_wren", 16'(o_wren_fifo), 16'd0);
    idle(6, 1'b0);

    // Push/pop collision in the WRITE cycle with a full buffer
    cyc(1'b1, 1'b1, 8'h11, 1'b1);
    cyc(1'b1, 1'b1, 8'h22, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'h44, 1'b0);
    idle(8, 1'b0);
    #1;
    check("coll_drop", 16'(o_drop_count), 16'd1);

    // Reset mid-stall
    cyc(1'b1, 1'b1, 8'h5A, 1'b1);
    cyc(1'b1, 1'b1, 8'h6B, 1'b1);
    cyc(1'b0, 1'b1, 8'h99, 1'b1);
    idle(4, 1'b0);
    #1;
    check("mrst_busy", 16'(o_busy), 16'd0);
    check("mrst_data", 16'(o_fifo_data), 16'd0);
    check("mrst_ovr",  16'(o_overrun), 16'd0);
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    check("mrst_77", 16'(o_fifo_data), 16'h77);
    idle(4, 1'b0);

    // Drop counter saturation: 2 held, 6 dropped
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 8'(8'hC0 + i), 1'b1);
    #1;
    check("sat_3", 16'(o_drop_count), 16'd3);
    cyc(1'b1, 1'b1, 8'hCF, 1'b1);
    #1;
    check("sat_hold", 16'(o_drop_count), 16'd3);
    idle(6, 1'b0);

    // Random traffic
    r_f = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r_r = ($urandom_range(0, 399) != 0);
      r_v = ($urandom_range(0, 2) == 0);
      r_d = 8'($urandom);
      if ($urandom_range(0, 5) == 0) r_f = ~r_f;
      cyc(r_r, r_v, r_d, r_f);
    end
    idle(8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
